pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and pipeline-control unit for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow record of destination registers in flight in EX, MEM and WB.
- Produces PC/IF-ID enables, per-stage flush (bubble) strobes and registered EX forwarding selects.
- Handles load-use stalls, full RAW stalls when forwarding is disabled, and control redirects resolved in EX or MEM.
- Keeps saturating stall and flush counters for debug display.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and pipeline control for a 5-stage RV32I core.
// Tracks destination registers in flight in EX/MEM/WB, drives PC/IF-ID enables,
// bubble strobes and registered EX forwarding selects, and counts stalls/redirects.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FWD_EN       = 1,
    parameter int RF_WB_BYPASS = 0,
    parameter int BR_STAGE     = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              redirect,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [REG_AW-1:0] X0      = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Shadow pipeline entries. Load-ness only matters while the producer sits in EX.
    logic              ex_valid_r, mem_valid_r, wb_valid_r;
    logic [REG_AW-1:0] ex_rd_r, mem_rd_r, wb_rd_r;
    logic              ex_regwrite_r, mem_regwrite_r, wb_regwrite_r;
    logic              ex_memread_r;

    logic ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s, wb_m1_s, wb_m2_s;
    logic stall_raw_s, stall_s, redir_s, advance_s;
    logic [1:0] fwd_a_nxt_s, fwd_b_nxt_s;

    // A producer matches an ID source when it writes a non-x0 register the ID instruction reads.
    assign ex_m1_s  = ex_valid_r  & ex_regwrite_r  & (ex_rd_r  != X0) & id_valid & id_use_rs1 & (id_rs1 == ex_rd_r);
    assign ex_m2_s  = ex_valid_r  & ex_regwrite_r  & (ex_rd_r  != X0) & id_valid & id_use_rs2 & (id_rs2 == ex_rd_r);
    assign mem_m1_s = mem_valid_r & mem_regwrite_r & (mem_rd_r != X0) & id_valid & id_use_rs1 & (id_rs1 == mem_rd_r);
    assign mem_m2_s = mem_valid_r & mem_regwrite_r & (mem_rd_r != X0) & id_valid & id_use_rs2 & (id_rs2 == mem_rd_r);
    assign wb_m1_s  = wb_valid_r  & wb_regwrite_r  & (wb_rd_r  != X0) & id_valid & id_use_rs1 & (id_rs1 == wb_rd_r);
    assign wb_m2_s  = wb_valid_r  & wb_regwrite_r  & (wb_rd_r  != X0) & id_valid & id_use_rs2 & (id_rs2 == wb_rd_r);

    // Raw stall request: load-use only with forwarding, every visible RAW hazard without it.
    always_comb begin
        stall_raw_s = 1'b0;
        if (FWD_EN != 0) begin
            stall_raw_s = ex_memread_r & (ex_m1_s | ex_m2_s);
        end else begin
            stall_raw_s = ex_m1_s | ex_m2_s | mem_m1_s | mem_m2_s |
                          ((RF_WB_BYPASS == 0) & (wb_m1_s | wb_m2_s));
        end
    end

    // Reset forces idle outputs; a redirect overrides any stall in the same cycle.
    assign redir_s   = ~rst & redirect;
    assign stall_s   = ~rst & stall_raw_s & ~redir_s;
    assign advance_s = id_valid & ~stall_s & ~redir_s;

    // Pipeline enables and bubble strobes, combinational from shadow state and inputs.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (redir_s) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = (BR_STAGE == 2);
        end else if (stall_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end
    end

    // Forwarding select for the instruction about to enter EX; youngest producer wins.
    always_comb begin
        fwd_a_nxt_s = 2'b00;
        fwd_b_nxt_s = 2'b00;
        if ((FWD_EN != 0) && advance_s) begin
            if (ex_m1_s) begin
                fwd_a_nxt_s = 2'b01;
            end else if (mem_m1_s) begin
                fwd_a_nxt_s = 2'b10;
            end else begin
                fwd_a_nxt_s = 2'b00;
            end
            if (ex_m2_s) begin
                fwd_b_nxt_s = 2'b01;
            end else if (mem_m2_s) begin
                fwd_b_nxt_s = 2'b10;
            end else begin
                fwd_b_nxt_s = 2'b00;
            end
        end else begin
            fwd_a_nxt_s = 2'b00;
            fwd_b_nxt_s = 2'b00;
        end
    end

    // Shadow pipeline advance, registered forwarding selects and saturating debug counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r     <= 1'b0;
            ex_rd_r        <= X0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            mem_valid_r    <= 1'b0;
            mem_rd_r       <= X0;
            mem_regwrite_r <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= X0;
            wb_regwrite_r  <= 1'b0;
            fwd_a_sel      <= 2'b00;
            fwd_b_sel      <= 2'b00;
            stall_cnt      <= {CNT_W{1'b0}};
            flush_cnt      <= {CNT_W{1'b0}};
        end else begin
            ex_valid_r     <= advance_s;
            ex_rd_r        <= id_rd;
            ex_regwrite_r  <= id_regwrite;
            ex_memread_r   <= id_memread;
            mem_valid_r    <= ex_valid_r & ~ex_mem_flush;
            mem_rd_r       <= ex_rd_r;
            mem_regwrite_r <= ex_regwrite_r;
            wb_valid_r     <= mem_valid_r;
            wb_rd_r        <= mem_rd_r;
            wb_regwrite_r  <= mem_regwrite_r;
            fwd_a_sel      <= fwd_a_nxt_s;
            fwd_b_sel      <= fwd_b_nxt_s;
            if (stall_s && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (redir_s && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Four instances share one ID/redirect
// stream: 0 = forwarding, branch in MEM; 1 = no forwarding, no WB bypass, 2-bit counters;
// 2 = no forwarding with WB bypass; 3 = forwarding, branch in EX. Each phase resets all
// instances and checks one of them. Expected forwarding selects are queued when an
// instruction is driven and popped in the following (EX) cycle.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] IDLE = 5'b11000; // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [4:0] STL  = 5'b00010;
    localparam logic [4:0] RD2  = 5'b11111;
    localparam logic [4:0] RD1  = 5'b11110;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic       redirect;

    logic [3:0]  pc_en_v, if_id_en_v, if_id_flush_v, id_ex_flush_v, ex_mem_flush_v;
    logic [7:0]  fwd_a_v, fwd_b_v;
    logic [63:0] sc_v, fc_v;

    int checks = 0;
    int fails  = 0;
    logic [3:0] exp_q[$];

    assign sc_v[31:18] = 14'd0;
    assign fc_v[31:18] = 14'd0;

    pipe_hazard_ctrl #(.FWD_EN(1), .RF_WB_BYPASS(0), .BR_STAGE(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .pc_en(pc_en_v[0]), .if_id_en(if_id_en_v[0]), .if_id_flush(if_id_flush_v[0]),
        .id_ex_flush(id_ex_flush_v[0]), .ex_mem_flush(ex_mem_flush_v[0]),
        .fwd_a_sel(fwd_a_v[1:0]), .fwd_b_sel(fwd_b_v[1:0]),
        .stall_cnt(sc_v[15:0]), .flush_cnt(fc_v[15:0]));

    pipe_hazard_ctrl #(.FWD_EN(0), .RF_WB_BYPASS(0), .BR_STAGE(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .pc_en(pc_en_v[1]), .if_id_en(if_id_en_v[1]), .if_id_flush(if_id_flush_v[1]),
        .id_ex_flush(id_ex_flush_v[1]), .ex_mem_flush(ex_mem_flush_v[1]),
        .fwd_a_sel(fwd_a_v[3:2]), .fwd_b_sel(fwd_b_v[3:2]),
        .stall_cnt(sc_v[17:16]), .flush_cnt(fc_v[17:16]));

    pipe_hazard_ctrl #(.FWD_EN(0), .RF_WB_BYPASS(1), .BR_STAGE(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .pc_en(pc_en_v[2]), .if_id_en(if_id_en_v[2]), .if_id_flush(if_id_flush_v[2]),
        .id_ex_flush(id_ex_flush_v[2]), .ex_mem_flush(ex_mem_flush_v[2]),
        .fwd_a_sel(fwd_a_v[5:4]), .fwd_b_sel(fwd_b_v[5:4]),
        .stall_cnt(sc_v[47:32]), .flush_cnt(fc_v[47:32]));

    pipe_hazard_ctrl #(.FWD_EN(1), .RF_WB_BYPASS(0), .BR_STAGE(1), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .pc_en(pc_en_v[3]), .if_id_en(if_id_en_v[3]), .if_id_flush(if_id_flush_v[3]),
        .id_ex_flush(id_ex_flush_v[3]), .ex_mem_flush(ex_mem_flush_v[3]),
        .fwd_a_sel(fwd_a_v[7:6]), .fwd_b_sel(fwd_b_v[7:6]),
        .stall_cnt(sc_v[63:48]), .flush_cnt(fc_v[63:48]));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] ctrl_of(input int sel);
        return {pc_en_v[sel], if_id_en_v[sel], if_id_flush_v[sel], id_ex_flush_v[sel], ex_mem_flush_v[sel]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnt(input int sel, input string tag, input logic [15:0] es, input logic [15:0] ef);
        chk({tag, " stall_cnt"}, sc_v[16*sel +: 16], es);
        chk({tag, " flush_cnt"}, fc_v[16*sel +: 16], ef);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic rdr);
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd;    id_regwrite = rw; id_memread = mr; redirect = rdr;
    endtask

    // One cycle: drive ID, check the selects registered last cycle, queue this cycle's, check controls.
    task automatic step(input int sel, input string tag, input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic rdr,
                        input logic [4:0] exp_ctrl, input logic [3:0] exp_fwd);
        logic [3:0] e;
        drive(v, rs1, rs2, u1, u2, rd, rw, mr, rdr);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " fwd_a_sel"}, 16'(fwd_a_v[2*sel +: 2]), 16'(e[3:2]));
            chk({tag, " fwd_b_sel"}, 16'(fwd_b_v[2*sel +: 2]), 16'(e[1:0]));
        end
        exp_q.push_back(exp_fwd);
        chk({tag, " ctrl"}, 16'(ctrl_of(sel)), 16'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with a hazard-looking ID instruction; outputs must stay idle.
    task automatic do_reset(input int sel);
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_q.delete();
        @(negedge clk);
        chk("rst1 ctrl", 16'(ctrl_of(sel)), 16'(IDLE));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst2 ctrl", 16'(ctrl_of(sel)), 16'(IDLE));
        chk("rst2 fwd_a_sel", 16'(fwd_a_v[2*sel +: 2]), 16'd0);
        chk("rst2 fwd_b_sel", 16'(fwd_b_v[2*sel +: 2]), 16'd0);
        chk_cnt(sel, "rst2", 16'd0, 16'd0);
        exp_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Forwarding from EX/MEM (distance 1) and MEM/WB (distance 2)
        do_reset(0);
        step(0, "A1 add x5",        1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        step(0, "A2 sub x6,x5,x1",  1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, IDLE, 4'b0100);
        step(0, "A3 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);
        step(0, "A4 add x5",        1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        step(0, "A5 add x7",        1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        step(0, "A6 sub x6,x5,x1",  1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, IDLE, 4'b1000);
        step(0, "A7 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);

        // Load-use: one stall cycle, selects cleared while held, then MEM/WB forward on rs2
        step(0, "B1 lw x6",         1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, IDLE, 4'b0000);
        step(0, "B2 add x7,x1,x6",  1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, STL,  4'b0000);
        step(0, "B3 add x7 retry",  1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, IDLE, 4'b0010);
        step(0, "B4 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);
        chk_cnt(0, "B load-use", 16'd1, 16'd0);

        // x0 producer never creates a hazard, even as a load
        step(0, "C1 lw x0",         1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, IDLE, 4'b0000);
        step(0, "C2 use x0",        1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        step(0, "C3 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);
        chk_cnt(0, "C x0", 16'd1, 16'd0);

        // Redirect in MEM, then redirect coinciding with a load-use hazard
        step(0, "D1 redirect",      1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, RD2,  4'b0000);
        chk_cnt(0, "D1 redirect", 16'd1, 16'd1);
        step(0, "D2 lw x6",         1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, IDLE, 4'b0000);
        step(0, "D3 redir+ld-use",  1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, RD2,  4'b0000);
        chk_cnt(0, "D3 redir+ld-use", 16'd1, 16'd2);
        step(0, "D4 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);

        // Branch resolved in EX: no EX/MEM flush
        do_reset(3);
        step(3, "E1 redirect br1",  1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, RD1,  4'b0000);
        chk_cnt(3, "E1 redirect br1", 16'd0, 16'd1);
        step(3, "E2 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);

        // No forwarding, no WB bypass: 3 stalls per back-to-back RAW, 2-bit counter saturates
        do_reset(1);
        step(1, "F1 add x5",        1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1, "F2 sub x6 stall", 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, STL, 4'b0000);
        end
        step(1, "F5 sub x6 go",     1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        chk_cnt(1, "F raw x3", 16'd3, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, "F6 add x7 stall", 1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, STL, 4'b0000);
        end
        step(1, "F9 add x7 go",     1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        chk_cnt(1, "F saturate", 16'd3, 16'd0);

        // No forwarding with WB write-through: 2 stalls per back-to-back RAW
        do_reset(2);
        step(2, "G1 add x5",        1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            step(2, "G2 sub x6 stall", 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, STL, 4'b0000);
        end
        step(2, "G4 sub x6 go",     1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, IDLE, 4'b0000);
        chk_cnt(2, "G bypass", 16'd2, 16'd0);
        step(2, "G5 bubble",        1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
